// File: rtl/palette_lut_if.sv
// Write, lookup and status signals of the palette LUT, grouped as one bus.
interface palette_lut_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              defer_en;
  logic              blank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;
  logic              fifo_empty;
  logic              init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, defer_en, blank, rd_en, rd_addr_a, rd_addr_b,
    input  wr_ready, rd_data_a, rd_data_b, rd_valid, fifo_empty, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, defer_en, blank, rd_en, rd_addr_a, rd_addr_b,
    output wr_ready, rd_data_a, rd_data_b, rd_valid, fifo_empty, init_busy
  );
endinterface

// File: rtl/palette_lut.sv
// Palette lookup table: dual-pixel registered lookup, immediate or blanking-deferred
// writes through a small ordered queue, and a post-reset clear sweep.
module palette_lut_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  always_ff @(posedge clk) begin
    if (reset)   dout <= '0;
    else if (en) dout <= din;
  end
endmodule

module palette_lut #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  palette_lut_if.slave bus
);
  localparam int ENTRIES = 2 ** ADDR_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LANES   = 2;
  localparam int STAGES  = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {S_INIT, S_RUN} state_t;

  logic [DATA_W-1:0] mem  [ENTRIES];
  wr_req_t           fifo [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  state_t            state;
  logic              init_busy;
  logic [ADDR_W-1:0] clr_idx;
  logic              full, empty, accept, direct, push, pop;
  wr_req_t           wr_req, head;

  // Pointers carry one wrap bit so full and empty differ.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign wr_req = '{addr: bus.wr_addr, data: bus.wr_data};
  assign head   = fifo[rd_ptr[PTR_W-1:0]];

  // Direct commit needs an empty queue and pop needs a non-empty one,
  // so the single memory write port is never contended.
  assign accept = bus.wr_en && bus.wr_ready;
  assign direct = accept && !bus.defer_en && empty;
  assign push   = accept && !direct;
  assign pop    = !empty && (bus.blank || !bus.defer_en);

  assign bus.wr_ready   = !init_busy && !full;
  assign bus.fifo_empty = empty;
  assign bus.init_busy  = init_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      init_busy <= 1'b1;
      clr_idx   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == ADDR_W'(ENTRIES - 1)) begin
            state     <= S_RUN;
            init_busy <= 1'b0;
          end
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_INIT;
      endcase
    end
  end

  // Memory is not reset; it only changes by the clear sweep or a commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_busy)   mem[clr_idx]   <= '0;
      else if (direct) mem[wr_addr_q()] <= bus.wr_data;
      else if (pop)    mem[head.addr] <= head.data;
    end
  end

  function automatic logic [ADDR_W-1:0] wr_addr_q();
    return bus.wr_addr;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo[wr_ptr[PTR_W-1:0]] <= wr_req;
  end

  // Lookup lanes: memory is sampled before this edge's commit lands.
  logic [LANES-1:0][ADDR_W-1:0] rd_addr;
  logic [LANES-1:0][DATA_W-1:0] lane_in, rd_data;

  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  always_comb begin
    lane_in = '0;
    for (int l = 0; l < LANES; l++) lane_in[l] = mem[rd_addr[l]];
  end

  palette_lut_lane #(.DATA_W(DATA_W)) u_lane [LANES-1:0] (
    .clk  (clk),
    .reset(reset),
    .en   (bus.rd_en),
    .din  (lane_in),
    .dout (rd_data)
  );

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];

  logic [STAGES:0] vld_pipe;
  assign vld_pipe[0] = bus.rd_en;

  always_ff @(posedge clk) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign bus.rd_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: init sweep, immediate/deferred writes, full queue, mode switch, mid-op reset.
module tb_palette_lut;
  logic clk, reset;
  int   n_chk = 0;
  int   n_err = 0;

  palette_lut_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  palette_lut #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[3:0];
    bus.wr_data = d[7:0];
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd_pair(input string tag, input int a, input int b, input int ea, input int eb);
    bus.rd_en     = 1'b1;
    bus.rd_addr_a = a[3:0];
    bus.rd_addr_b = b[3:0];
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk({tag, ".vld"}, bus.rd_valid, 1);
    chk({tag, ".a"}, bus.rd_data_a, ea);
    chk({tag, ".b"}, bus.rd_data_b, eb);
  endtask

  task automatic wait_init();
    int cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.init_busy) break;
      cycles++;
    end
    chk("init.len", cycles, 16);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.defer_en = 0; bus.blank = 0;
    bus.rd_en = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    repeat (2) @(negedge clk);
    chk("rst.rd_a", bus.rd_data_a, 0);
    chk("rst.rd_b", bus.rd_data_b, 0);
    chk("rst.vld", bus.rd_valid, 0);
    chk("rst.rdy", bus.wr_ready, 0);
    chk("rst.empty", bus.fifo_empty, 1);
    chk("rst.busy", bus.init_busy, 1);

    // A write held during the clear must be dropped.
    reset = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'hEE;
    wait_init();
    bus.wr_en = 1'b0;
    chk("init.empty", bus.fifo_empty, 1);
    rd_pair("init.rd", 3, 15, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd.idle_vld", bus.rd_valid, 0);
    rd_pair("init.drop", 0, 0, 8'h00, 8'h00);

    // Immediate write with a same-edge read of the old value.
    chk("imm.rdy", bus.wr_ready, 1);
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd5;
    wr(5, 8'hA7);
    bus.rd_en = 1'b0;
    chk("imm.old_a", bus.rd_data_a, 8'h00);
    chk("imm.old_b", bus.rd_data_b, 8'h00);
    rd_pair("imm.new", 5, 5, 8'hA7, 8'hA7);
    @(negedge clk);
    chk("rd.hold_vld", bus.rd_valid, 0);
    chk("rd.hold_a", bus.rd_data_a, 8'hA7);

    // Deferred writes held until blanking.
    bus.defer_en = 1'b1; bus.blank = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("dq.rdy", bus.wr_ready, 1);
      wr(i, i * 8'h11);
    end
    chk("dq.full_rdy", bus.wr_ready, 0);
    chk("dq.empty", bus.fifo_empty, 0);
    rd_pair("dq.held", 1, 4, 8'h00, 8'h00);
    bus.blank = 1'b1;
    @(negedge clk);
    rd_pair("dq.order", 1, 2, 8'h11, 8'h00);
    chk("dq.e2", bus.fifo_empty, 0);
    @(negedge clk);
    chk("dq.e3", bus.fifo_empty, 0);
    @(negedge clk);
    chk("dq.e4", bus.fifo_empty, 1);
    bus.blank = 1'b0;
    rd_pair("dq.r12", 1, 2, 8'h11, 8'h22);
    rd_pair("dq.r34", 3, 4, 8'h33, 8'h44);

    // Full queue: refused write while popping, then push+pop keeps occupancy.
    for (int i = 6; i <= 9; i++) wr(i, i * 8'h11);
    chk("fp.full", bus.wr_ready, 0);
    bus.blank = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd10; bus.wr_data = 8'hAA;
    @(negedge clk);
    chk("fp.rdy_after_pop", bus.wr_ready, 1);
    bus.wr_addr = 4'd11; bus.wr_data = 8'hBB;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.blank = 1'b0;
    chk("fp.occ3_rdy", bus.wr_ready, 1);
    chk("fp.occ3_nempty", bus.fifo_empty, 0);
    wr(12, 8'hCC);
    chk("fp.occ4", bus.wr_ready, 0);
    bus.blank = 1'b1;
    n = 0;
    while (!bus.fifo_empty && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("fp.drain", n, 4);
    bus.blank = 1'b0;
    rd_pair("fp.drop", 10, 11, 8'h00, 8'hBB);
    rd_pair("fp.r6_12", 6, 12, 8'h66, 8'hCC);
    rd_pair("fp.r8_9", 8, 9, 8'h88, 8'h99);

    // Mode switch drains in order; a write issued mid-drain lands last.
    wr(13, 8'hD1);
    wr(14, 8'hE2);
    bus.defer_en = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd13; bus.wr_data = 8'h5A;
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd13; bus.rd_addr_b = 4'd14;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("ms.ord_a", bus.rd_data_a, 8'hD1);
    chk("ms.ord_b", bus.rd_data_b, 8'h00);
    chk("ms.nempty", bus.fifo_empty, 0);
    @(negedge clk);
    chk("ms.empty", bus.fifo_empty, 1);
    rd_pair("ms.final", 13, 14, 8'h5A, 8'hE2);

    // Mid-operation reset discards the queue and restarts the clear.
    wr(7, 8'h70);
    bus.defer_en = 1'b1;
    wr(0, 8'hF1);
    wr(1, 8'hF2);
    wr(2, 8'hF3);
    chk("mr.queued", bus.fifo_empty, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mr.empty", bus.fifo_empty, 1);
    chk("mr.busy", bus.init_busy, 1);
    chk("mr.rdy", bus.wr_ready, 0);
    chk("mr.vld", bus.rd_valid, 0);
    chk("mr.rd_a", bus.rd_data_a, 0);
    reset = 1'b0;
    bus.defer_en = 1'b0;
    wait_init();
    chk("mr.empty2", bus.fifo_empty, 1);
    for (int i = 0; i < 8; i++) rd_pair("mr.clr", i, i + 8, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 Parameter ADDR_W, default 4: palette index width; 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 8: colour entry width.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >=2: deferred-write queue depth.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
REQ-005 The block SHALL have the following ports:
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write value
- wr_ready  out  1  write accepted this cycle when wr_en=1
- defer_en  in  1  1 = queue writes until blanking
- blank  in  1  video blanking window
- rd_en  in  1  pixel-pair lookup request
- rd_addr_a  in  ADDR_W  first pixel index
- rd_addr_b  in  ADDR_W  second pixel index
- rd_data_a  out  DATA_W  colour for rd_addr_a
- rd_data_b  out  DATA_W  colour for rd_addr_b
- rd_valid  out  1  rd_data_a/b updated this cycle
- fifo_empty  out  1  no queued writes
- init_busy  out  1  clear sequence running

Function
REQ-006 After reset deasserts, the block SHALL clear every entry to 0, one entry per cycle in ascending index order, holding init_busy=1 for exactly 2**ADDR_W cycles.
REQ-007 wr_ready SHALL be 0 while init_busy=1; a wr_en with wr_ready=0 SHALL be dropped with no side effect.
REQ-008 Otherwise wr_ready SHALL equal !(queue full), computed from registered state only, independent of the same-cycle pop.
REQ-009 An accepted write SHALL commit directly to memory on the next edge only when defer_en=1'b0 and the queue is empty; in every other case it SHALL be pushed to the queue.
REQ-010 The queue SHALL pop and commit one entry per cycle while non-empty and (blank=1 or defer_en=0); commit order SHALL equal acceptance order.
REQ-011 A simultaneous push and pop SHALL both take effect, leaving the occupancy unchanged.
REQ-012 Queue pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit so that full and empty are distinguishable.
REQ-013 A direct write and a queue pop SHALL never coincide, as guaranteed by REQ-009.
REQ-014 rd_en=1 at edge N SHALL present mem[rd_addr_a] and mem[rd_addr_b] on rd_data_a/b with rd_valid=1 after edge N, a one-cycle latency.
REQ-015 rd_valid SHALL be 0 on the cycle after any edge where rd_en=0; rd_data_a/b SHALL then hold their previous values.
REQ-016 A read and a commit to the same index at the same edge SHALL return the old value (read-before-write).
REQ-017 rd_addr_a equal to rd_addr_b SHALL be legal and return identical data on both outputs.
REQ-018 Reads during init SHALL be honoured and return whatever the clear has reached, either 0 or the pre-reset contents.
REQ-019 fifo_empty SHALL be a registered-state output with no combinational input-to-output path.

Reset
REQ-020 While reset=1: rd_data_a=0, rd_data_b=0, rd_valid=0, wr_ready=0, fifo_empty=1, init_busy=1, and the queue pointers are zeroed.
REQ-021 Reset asserted mid-operation SHALL discard all queued writes and abort any clear in progress; the clear SHALL restart from index 0 when reset deasserts.
REQ-022 Memory contents SHALL change only through the clear sequence or committed writes; reset itself SHALL not require a single-cycle memory clear.

Verification
REQ-023 Init: release reset -> init_busy=1 for 16 cycles, then 0; a read of indices 3 and 15 returns 0x00/0x00 with rd_valid=1 one cycle after rd_en.
REQ-024 Immediate: defer_en=0, write idx 5=0xA7 -> on the next cycle rd_en with a=5, b=5 returns 0xA7/0xA7; a same-edge read of idx 5 returns the old value 0x00.
REQ-025 Deferred: defer_en=1, blank=0, write idx 1..4 = 0x11..0x44 -> wr_ready=0 after the 4th write and reads return 0; then blank=1 -> the four commits complete in 4 cycles, in order, and fifo_empty=1.
REQ-026 Full with pop: queue full, blank=1, wr_en with wr_ready=0 -> dropped; on the next cycle wr_ready=1, and a push concurrent with a pop keeps occupancy at 3.
REQ-027 Mode switch: 2 queued writes, defer_en 1->0 with blank=0 -> both commit in order over 2 cycles; a new write issued during the drain lands after them.
REQ-028 Mid-op reset: 3 queued writes plus 1 direct write -> reset for 1 cycle -> queued writes are lost, all entries read 0 after the 16-cycle clear, and fifo_empty=1.
